ervp_plic_claim_engine: RTL

Hardware claim/complete sequencer for the platform PLIC. When the PLIC interrupt output is asserted, the block acts as an APB master toward the PLIC register window and reads the context-0 claim register. Non-zero IDs are buffered in a small FIFO and presented to a consumer (core-side handler or DMA trigger logic) over a valid/ready port. Completion IDs from the consumer are written back to the same register, with completion traffic given priority over new claims.

---
 rtl/ervp_plic_claim_engine.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ervp_plic_claim_engine.sv
`timescale 1ns/1ps
// APB master that claims pending PLIC interrupt IDs into a small FIFO for a consumer
// and writes completion IDs back to the same claim/complete register.
module ervp_plic_claim_engine #(
  parameter logic [31:0] PLIC_BASE    = 32'h0c000000,
  parameter logic [31:0] CLAIM_OFFSET = 32'h00200004,
  parameter int          BW_ID        = 10,
  parameter int          DEPTH        = 4,
  parameter int          TIMEOUT      = 255,
  parameter int          HOLDOFF      = 2
) (
  input  logic                     clk,
  input  logic                     rstnn,
  input  logic                     enable,
  input  logic                     plic_interrupt,
  output logic                     rpsel,
  output logic                     rpenable,
  output logic                     rpwrite,
  output logic [31:0]              rpaddr,
  output logic [31:0]              rpwdata,
  input  logic [31:0]              rprdata,
  input  logic                     rpready,
  input  logic                     rpslverr,
  output logic                     claim_valid,
  output logic [BW_ID-1:0]         claim_id,
  input  logic                     claim_ready,
  input  logic                     complete_valid,
  input  logic [BW_ID-1:0]         complete_id,
  output logic                     complete_ready,
  output logic [$clog2(DEPTH):0]   claim_count,
  output logic                     apb_error,
  output logic                     busy
);

  localparam int          PW           = $clog2(DEPTH);
  localparam logic [31:0] CLAIM_ADDR   = PLIC_BASE + CLAIM_OFFSET;
  localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0]  HOLDOFF_C    = 8'(HOLDOFF);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_e;

  state_e           state_q, state_d;
  logic             op_write_q;
  logic [BW_ID-1:0] id_q;
  logic [7:0]       timer_q;
  logic [7:0]       holdoff_q;
  logic             apb_error_q;
  logic [BW_ID-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;

  logic start_read, timed_out, xfer_done, xfer_err, push, pop;

  // DEPTH is a power of two, so the FIFO is full exactly when the count MSB is set.
  assign start_read = enable & plic_interrupt & ~count_q[PW] & (holdoff_q == 8'd0)
                      & ~complete_valid;
  assign timed_out  = (state_q == S_ACCESS) & ~rpready & (timer_q == TIMEOUT_LAST);
  assign xfer_done  = (state_q == S_ACCESS) & (rpready | timed_out);
  assign xfer_err   = (state_q == S_ACCESS) & ((rpready & rpslverr) | timed_out);
  assign push       = (state_q == S_ACCESS) & rpready & ~rpslverr & ~op_write_q
                      & (rprdata[BW_ID-1:0] != '0);
  assign pop        = claim_valid & claim_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rstnn) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (complete_valid || start_read) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (rpready || timed_out) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case, so no path can infer a latch.
  always_comb begin
    rpsel          = 1'b0;
    rpenable       = 1'b0;
    rpwrite        = 1'b0;
    rpaddr         = '0;
    rpwdata        = '0;
    busy           = 1'b0;
    complete_ready = 1'b0;
    unique case (state_q)
      S_IDLE: complete_ready = 1'b1;
      S_SETUP, S_ACCESS: begin
        rpsel    = 1'b1;
        rpenable = (state_q == S_ACCESS);
        busy     = 1'b1;
        rpwrite  = op_write_q;
        rpaddr   = CLAIM_ADDR;
        rpwdata  = op_write_q ? 32'(id_q) : 32'h0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstnn) begin
      op_write_q  <= 1'b0;
      id_q        <= '0;
      timer_q     <= '0;
      holdoff_q   <= '0;
      apb_error_q <= 1'b0;
    end else begin
      apb_error_q <= xfer_err;
      if (state_q == S_IDLE && complete_valid) begin
        op_write_q <= 1'b1;
        id_q       <= complete_id;
      end else if (state_q == S_IDLE && start_read) begin
        op_write_q <= 1'b0;
      end
      if (state_q == S_SETUP)                    timer_q <= '0;
      else if (state_q == S_ACCESS && !rpready)  timer_q <= timer_q + 8'd1;
      // Holdoff only throttles claims; it restarts on every read, failed or not.
      if (xfer_done && !op_write_q)  holdoff_q <= HOLDOFF_C;
      else if (holdoff_q != 8'd0)    holdoff_q <= holdoff_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstnn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + (PW+1)'(1);
      else if (pop && !push) count_q <= count_q - (PW+1)'(1);
    end
  end

  // NOTE: FIFO storage is deliberately not reset; claim_id is masked by claim_valid,
  // so a stale entry is never visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rprdata[BW_ID-1:0];
  end

  assign claim_valid = (count_q != '0);
  assign claim_id    = claim_valid ? mem_q[rd_ptr_q] : '0;
  assign claim_count = count_q;
  assign apb_error   = apb_error_q;

  // Upper read-data bits carry no ID information.
  logic unused_rdata;
  assign unused_rdata = ^rprdata[31:BW_ID];

endmodule
